mem_access_stage: RTL
=====================

// Module: mem_access_stage
// PURPOSE
//  MEM-stage data access unit, directly downstream of the EX/MEM register and upstream of WB.
//  Decodes the memory op, checks address legality (AdEL/AdES) and issues one bus transaction
//  to the bridge, which fronts the DM and timers. Handles bridge wait states by stalling the
//  pipeline, then extends load data. Registers the MEM/WB stage (W_*) outputs.
// PARAMETERS
//  DM_END     32'h0000_3000  first address past data memory (DM = [0, DM_END))
//  TC0_BASE   32'h0000_7F00  timer0 base; 3 word registers, offsets 0/4/8
//  TC1_BASE   32'h0000_7F10  timer1 base; same layout
//  PC_KERNEL  32'h0000_4180  W_PC value loaded on exception/interrupt flush
// PORTS
//  clk          in   1   clock, posedge
//  reset        in   1   asynchronous, active-low (0 = reset)
//  M_valid      in   1   EX/MEM holds a real instruction (0 = bubble)
//  M_mem_op     in   4   mem_op_t: NONE,LW,LH,LHU,LB,LBU,SW,SH,SB
//  M_addr       in   32  effective address (EX/MEM ALU result)
//  M_wdata      in   32  store data (forwarded RD2)
//  M_addr_ovf   in   1   overflow during address add
//  M_PC         in   32  PC of M instruction
//  M_instr      in   32  instruction word, passed through
//  M_exc_code   in   5   exception code from earlier stages (0 = none)
//  int_exc_req  in   1   CP0 flush request
//  bus_req      out  1   access request to bridge
//  bus_we       out  1   1 = write
//  bus_addr     out  32  word address {M_addr[31:2],2'b00}
//  bus_be       out  4   byte enables
//  bus_wdata    out  32  lane-replicated store data
//  bus_ready    in   1   bridge completes access this cycle (write commits only on this cycle)
//  bus_rdata    in   32  read word, valid when bus_ready
//  stall        out  1   freeze F/D/E stages and EX/MEM register
//  M_exc_out    out  5   resolved M-stage exception code, to CP0 (combinational)
//  W_valid, W_PC[32], W_instr[32], W_rdata[32], W_exc_code[5]   out   MEM/WB register
// BEHAVIOUR
//  Reset: state=IDLE; all W_* = 0; bus_req=0; stall=0.
//  Exception resolve (combinational, priority order):
//   M_exc_code!=0 -> pass through.
//   Load and (misaligned | addr_ovf | outside DM/timers | LH/LB to timer) -> 4 (AdEL).
//   Store with same rules, or store to timer offset 8 -> 5 (AdES).
//   Misaligned = LW/SW addr[1:0]!=0; LH*/SH addr[0]!=0.
//  go = M_valid & op!=NONE & M_exc_out==0 & ~int_exc_req.
//  FSM IDLE:
//   bus_req=go; stall=go&~bus_ready.
//   go&~bus_ready -> WAIT, latch addr/be/wdata/we.
//  FSM WAIT:
//   bus_req=1 with latched fields held stable; stall=~bus_ready.
//   bus_ready -> IDLE.
//  Zero-wait access: 0 stall cycles. N wait states: N stall cycles.
//  bus_be/wdata:
//   SW: 1111.
//   SH: addr[1] ? 1100 : 0011, wdata={2{wdata[15:0]}}.
//   SB: 0001<<addr[1:0], wdata={4{wdata[7:0]}}.
//   Loads: 1111.
//  Load extend: byte/half selected from bus_rdata by addr[1:0]; LB/LH sign-extend, LBU/LHU zero-extend.
//  W regs update every cycle with stall=0 and int_exc_req=0: copy M fields, W_rdata=extended data.
//   A stall cycle does not update W. A bubble (M_valid=0) gives W_valid=0.
//  int_exc_req (any state, highest priority):
//   state->IDLE, abandon pending access with no write committed, bus_req=0, stall=0.
//   W_* <= 0 except W_PC <= PC_KERNEL.
//  int_exc_req and bus_ready in the same cycle: flush wins; the ready is ignored.
//  Async reset mid-WAIT: immediate return to IDLE; bus_req drops without waiting for a clock edge.
// STRUCTURE
//  Shared package/header holds:
//   - mem_op_t encodings
//   - EXC_ADEL=4, EXC_ADES=5
//   - address map constants
//  One sub-module: mem_load_ext (combinational lane select + extension), 32b in / 32b out.
//  FSM, BE/lane logic and exception check stay in this module.
// TESTING
//  1. LW 0x0000_0010, bus_ready same cycle, rdata 0xDEADBEEF -> stall 0; next cycle W_rdata=0xDEADBEEF.
//  2. SB addr 0x0000_0003, wdata 0x0000_00A5, ready after 2 waits ->
//     be=1000, wdata=0xA5A5A5A5, stall high 2 cycles, addr held stable.
//  3. LB 0x0000_0002, rdata 0x0080_0000 -> W_rdata=0xFFFF_FF80; LBU -> 0x0000_0080.
//  4. Exception checks:
//     - LW 0x0000_0002 -> M_exc_out=4, bus_req=0.
//     - SW 0x0000_7F08 -> 5.
//     - SH 0x0000_7F00 -> 5.
//     - LW 0x0000_5000 -> 4.
//  5. SW in WAIT, int_exc_req pulsed with bus_ready=1 -> no commit, state IDLE,
//     W_PC=0x0000_4180, W_valid=0.
//  6. reset low during WAIT -> bus_req=0 and stall=0 before the next edge, all W_* = 0.

Source files
------------

// File: rtl/mem_access_stage_pkg.sv
// Shared definitions for the MEM-stage data access unit: op encodings,
// exception codes and the data-memory / timer address map.
package mem_access_stage_pkg;

  typedef enum logic [3:0] {
    OP_NONE = 4'd0,
    OP_LW   = 4'd1,
    OP_LH   = 4'd2,
    OP_LHU  = 4'd3,
    OP_LB   = 4'd4,
    OP_LBU  = 4'd5,
    OP_SW   = 4'd6,
    OP_SH   = 4'd7,
    OP_SB   = 4'd8
  } mem_op_t;

  localparam logic [4:0] EXC_NONE = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;

  localparam logic [31:0] DM_END    = 32'h0000_3000;
  localparam logic [31:0] TC0_BASE  = 32'h0000_7F00;
  localparam logic [31:0] TC1_BASE  = 32'h0000_7F10;
  localparam logic [31:0] TC_SPAN   = 32'd12;
  localparam logic [31:0] TC_CNT    = 32'd8;
  localparam logic [31:0] PC_KERNEL = 32'h0000_4180;

  function automatic logic op_is_load(mem_op_t op);
    return op inside {OP_LW, OP_LH, OP_LHU, OP_LB, OP_LBU};
  endfunction

  function automatic logic op_is_store(mem_op_t op);
    return op inside {OP_SW, OP_SH, OP_SB};
  endfunction

endpackage

// File: rtl/mem_load_ext.sv
// Load lane select and sign/zero extension of the bus read word.
module mem_load_ext
  import mem_access_stage_pkg::*;
(
  input  mem_op_t     op_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] rdata_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_c;
  logic [15:0] half_c;

  always_comb begin
    byte_c = rdata_i[7:0];
    case (addr_lo_i)
      2'd1:    byte_c = rdata_i[15:8];
      2'd2:    byte_c = rdata_i[23:16];
      2'd3:    byte_c = rdata_i[31:24];
      default: byte_c = rdata_i[7:0];
    endcase
    half_c = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];

    case (op_i)
      OP_LB:   data_o = {{24{byte_c[7]}}, byte_c};
      OP_LBU:  data_o = {24'd0, byte_c};
      OP_LH:   data_o = {{16{half_c[15]}}, half_c};
      OP_LHU:  data_o = {16'd0, half_c};
      default: data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// MEM-stage data access: address check, single bridge transaction with
// wait-state stalling, load extension and the MEM/WB register.
module mem_access_stage
  import mem_access_stage_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        M_valid,
  input  logic [3:0]  M_mem_op,
  input  logic [31:0] M_addr,
  input  logic [31:0] M_wdata,
  input  logic        M_addr_ovf,
  input  logic [31:0] M_PC,
  input  logic [31:0] M_instr,
  input  logic [4:0]  M_exc_code,
  input  logic        int_exc_req,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ready,
  input  logic [31:0] bus_rdata,
  output logic        stall,
  output logic [4:0]  M_exc_out,
  output logic        W_valid,
  output logic [31:0] W_PC,
  output logic [31:0] W_instr,
  output logic [31:0] W_rdata,
  output logic [4:0]  W_exc_code
);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;
  logic        we_q, we_d;

  mem_op_t     op;
  logic        ld, st, word_op, half_op, in_dm, in_tc, tc_cnt, misal, bad;
  logic        go;
  logic [3:0]  be_c;
  logic [31:0] wdata_c;
  logic [1:0]  lane_c;
  logic [31:0] ext_c;

  assign op = mem_op_t'(M_mem_op);

  // Address legality: DM or timer word registers; timers take only word access
  always_comb begin
    ld      = op_is_load(op);
    st      = op_is_store(op);
    word_op = (op == OP_LW) || (op == OP_SW);
    half_op = (op == OP_LH) || (op == OP_LHU) || (op == OP_SH);
    in_dm   = M_addr < DM_END;
    in_tc   = ((M_addr >= TC0_BASE) && (M_addr < TC0_BASE + TC_SPAN)) ||
              ((M_addr >= TC1_BASE) && (M_addr < TC1_BASE + TC_SPAN));
    tc_cnt  = (M_addr == TC0_BASE + TC_CNT) || (M_addr == TC1_BASE + TC_CNT);
    misal   = (word_op && (M_addr[1:0] != 2'b00)) || (half_op && M_addr[0]);
    bad     = misal || M_addr_ovf || !(in_dm || in_tc) || (in_tc && !word_op);

    M_exc_out = EXC_NONE;
    if (M_exc_code != EXC_NONE)   M_exc_out = M_exc_code;
    else if (ld && bad)           M_exc_out = EXC_ADEL;
    else if (st && (bad || tc_cnt)) M_exc_out = EXC_ADES;
  end

  assign go = M_valid && (op != OP_NONE) && (M_exc_out == EXC_NONE) && !int_exc_req;

  // Byte enables and lane-replicated store data
  always_comb begin
    be_c    = 4'b1111;
    wdata_c = M_wdata;
    case (op)
      OP_SH: begin
        be_c    = M_addr[1] ? 4'b1100 : 4'b0011;
        wdata_c = {2{M_wdata[15:0]}};
      end
      OP_SB: begin
        be_c    = 4'b0001 << M_addr[1:0];
        wdata_c = {4{M_wdata[7:0]}};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      we_q    <= we_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    be_d      = be_q;
    we_d      = we_q;
    bus_req   = 1'b0;
    bus_we    = st;
    bus_addr  = {M_addr[31:2], 2'b00};
    bus_be    = be_c;
    bus_wdata = wdata_c;
    stall     = 1'b0;

    case (state_q)
      S_IDLE: begin
        bus_req = go;
        stall   = go && !bus_ready;
        if (go && !bus_ready) begin
          state_d = S_WAIT;
          addr_d  = M_addr;
          wdata_d = wdata_c;
          be_d    = be_c;
          we_d    = st;
        end
      end
      S_WAIT: begin
        bus_req   = 1'b1;
        bus_we    = we_q;
        bus_addr  = {addr_q[31:2], 2'b00};
        bus_be    = be_q;
        bus_wdata = wdata_q;
        stall     = !bus_ready;
        if (bus_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Flush abandons the access outright; a coincident ready is ignored
    if (int_exc_req) begin
      state_d = S_IDLE;
      bus_req = 1'b0;
      stall   = 1'b0;
    end
    if (!reset) begin
      bus_req = 1'b0;
      stall   = 1'b0;
    end
  end

  assign lane_c = (state_q == S_WAIT) ? addr_q[1:0] : M_addr[1:0];

  mem_load_ext u_load_ext (
    .op_i      (op),
    .addr_lo_i (lane_c),
    .rdata_i   (bus_rdata),
    .data_o    (ext_c)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      W_valid    <= 1'b0;
      W_PC       <= '0;
      W_instr    <= '0;
      W_rdata    <= '0;
      W_exc_code <= '0;
    end else if (int_exc_req) begin
      W_valid    <= 1'b0;
      W_PC       <= PC_KERNEL;
      W_instr    <= '0;
      W_rdata    <= '0;
      W_exc_code <= '0;
    end else if (!stall) begin
      W_valid    <= M_valid;
      W_PC       <= M_PC;
      W_instr    <= M_instr;
      W_rdata    <= (go && ld) ? ext_c : 32'd0;
      W_exc_code <= M_exc_out;
    end
  end

endmodule
